// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
// Round-robin arbiter that shares the register file's single write port
// among NREQ writeback requesters. The winning write passes through one
// output register stage. A busy scoreboard flags registers that have a
// write reserved but not yet committed, so issue can stall on RAW hazards.

module regfile_write_arbiter #(
  parameter int NREQ = 3,
  parameter int DW   = 32,
  parameter int AW   = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*AW-1:0]    req_addr,
  input  logic [NREQ*DW-1:0]    req_data,
  output logic [NREQ-1:0]       req_ready,
  input  logic                  pend_set,
  input  logic [AW-1:0]         pend_addr,
  output logic [AW-1:0]         wa,
  output logic [DW-1:0]         wd,
  output logic                  we,
  output logic [(1<<AW)-1:0]    busy
);

  localparam int RW = $clog2(NREQ);
  localparam int NR = 1 << AW;

  logic [RW-1:0] rr;
  logic [RW-1:0] scan_idx;
  logic [RW-1:0] gnt_idx;
  logic          gnt_any;
  logic [NREQ-1:0] grant;
  logic [AW-1:0] gnt_addr;
  logic [DW-1:0] gnt_data;
  logic [NR-1:0] busy_next;

  // Scan requesters starting at rr, wrapping, and pick the first valid one
  always_comb begin
    grant    = '0;
    gnt_idx  = '0;
    gnt_any  = 1'b0;
    scan_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan_idx = RW'((int'(rr) + k) % NREQ);
      if (!gnt_any && req_valid[scan_idx]) begin
        gnt_any         = 1'b1;
        gnt_idx         = scan_idx;
        grant[scan_idx] = 1'b1;
      end
    end
  end

  // Grants are suppressed while reset is held so nothing is consumed
  assign req_ready = rst ? '0 : grant;

  assign gnt_addr = req_addr[gnt_idx*AW +: AW];
  assign gnt_data = req_data[gnt_idx*DW +: DW];

  // Advance the priority pointer past the winner; hold it when idle
  always_ff @(posedge clk) begin
    if (rst) begin
      rr <= '0;
    end else if (gnt_any) begin
      if (gnt_idx == RW'(NREQ - 1)) begin
        rr <= '0;
      end else begin
        rr <= gnt_idx + 1'b1;
      end
    end
  end

  // Output stage: a grant to a nonzero register becomes a write next cycle;
  // a grant to register 0 is swallowed and the address/data are left alone
  always_ff @(posedge clk) begin
    if (rst) begin
      we <= 1'b0;
      wa <= '0;
      wd <= '0;
    end else if (gnt_any && (gnt_addr != '0)) begin
      we <= 1'b1;
      wa <= gnt_addr;
      wd <= gnt_data;
    end else begin
      we <= 1'b0;
    end
  end

  // Scoreboard update: commit clears, reservation sets and wins a tie
  always_comb begin
    busy_next = busy;
    if (we) begin
      busy_next[wa] = 1'b0;
    end
    if (pend_set && (pend_addr != '0)) begin
      busy_next[pend_addr] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  // Scoreboard register
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
    end else begin
      busy <= busy_next;
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter
// Directed bench for the round-robin register file write arbiter.

module tb_regfile_write_arbiter;

  localparam int NREQ = 3;
  localparam int DW   = 32;
  localparam int AW   = 5;

  logic                clk;
  logic                rst;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ*AW-1:0]  req_addr;
  logic [NREQ*DW-1:0]  req_data;
  logic [NREQ-1:0]     req_ready;
  logic                pend_set;
  logic [AW-1:0]       pend_addr;
  logic [AW-1:0]       wa;
  logic [DW-1:0]       wd;
  logic                we;
  logic [(1<<AW)-1:0]  busy;

  int tests_run;
  int tests_failed;

  regfile_write_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .pend_set  (pend_set),
    .pend_addr (pend_addr),
    .wa        (wa),
    .wd        (wd),
    .we        (we),
    .busy      (busy)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value
  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive the per-cycle control inputs
  task automatic applyStimulus(input logic [NREQ-1:0] valid, input logic pset, input logic [AW-1:0] paddr);
    req_valid = valid;
    pend_set  = pset;
    pend_addr = paddr;
    #1;
  endtask

  // Load address and data for one requester
  task automatic setReq(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [AW-1:0] exp_addr [NREQ];
  logic [DW-1:0] exp_data [NREQ];
  int            wait_cycles;
  logic          req2_seen;

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    req_addr     = '0;
    req_data     = '0;
    exp_addr[0] = 5'd1;  exp_data[0] = 32'h0000_00A0;
    exp_addr[1] = 5'd2;  exp_data[1] = 32'h0000_00A1;
    exp_addr[2] = 5'd3;  exp_data[2] = 32'h0000_00A2;
    for (int i = 0; i < NREQ; i++) setReq(i, exp_addr[i], exp_data[i]);

    // Reset held for two cycles with every requester valid
    rst = 1'b1;
    applyStimulus(3'b111, 1'b0, '0);
    checkOutput("rst_ready_c0", 64'(req_ready), 64'h0);
    tick();
    checkOutput("rst_ready_c1", 64'(req_ready), 64'h0);
    tick();
    checkOutput("rst_we", 64'(we), 64'h0);
    checkOutput("rst_busy", 64'(busy), 64'h0);
    checkOutput("rst_ready_c2", 64'(req_ready), 64'h0);

    // Round-robin: all three valid for six cycles
    rst = 1'b0;
    #1;
    for (int c = 0; c < 6; c++) begin
      checkOutput($sformatf("rr_grant_%0d", c), 64'(req_ready), 64'(3'b001 << (c % 3)));
      if (c > 0) begin
        checkOutput($sformatf("rr_we_%0d", c), 64'(we), 64'h1);
        checkOutput($sformatf("rr_wa_%0d", c), 64'(wa), 64'(exp_addr[(c - 1) % 3]));
        checkOutput($sformatf("rr_wd_%0d", c), 64'(wd), 64'(exp_data[(c - 1) % 3]));
      end
      tick();
    end
    applyStimulus(3'b000, 1'b0, '0);
    checkOutput("rr_we_last", 64'(we), 64'h1);
    checkOutput("rr_wa_last", 64'(wa), 64'(exp_addr[2]));
    checkOutput("rr_busy_clean", 64'(busy), 64'h0);
    tick();
    checkOutput("rr_idle_we", 64'(we), 64'h0);

    // Single write from requester 1 (pointer is back at 0)
    setReq(1, 5'd7, 32'hDEAD_BEEF);
    applyStimulus(3'b010, 1'b0, '0);
    checkOutput("single_ready", 64'(req_ready), 64'h2);
    tick();
    applyStimulus(3'b000, 1'b0, '0);
    checkOutput("single_we", 64'(we), 64'h1);
    checkOutput("single_wa", 64'(wa), 64'd7);
    checkOutput("single_wd", 64'(wd), 64'hDEAD_BEEF);
    tick();
    checkOutput("single_we_off", 64'(we), 64'h0);
    checkOutput("single_wa_hold", 64'(wa), 64'd7);

    // Register 0: reservation ignored, grant consumed, no write (pointer at 2)
    applyStimulus(3'b000, 1'b1, 5'd0);
    tick();
    applyStimulus(3'b000, 1'b0, '0);
    checkOutput("r0_busy", 64'(busy), 64'h0);
    setReq(0, 5'd0, 32'h0000_0055);
    applyStimulus(3'b001, 1'b0, '0);
    checkOutput("r0_ready", 64'(req_ready), 64'h1);
    tick();
    applyStimulus(3'b000, 1'b0, '0);
    checkOutput("r0_we", 64'(we), 64'h0);
    checkOutput("r0_busy_after", 64'(busy), 64'h0);

    // Scoreboard: reserve r9, commit clears it (pointer at 1)
    applyStimulus(3'b000, 1'b1, 5'd9);
    tick();
    applyStimulus(3'b000, 1'b0, '0);
    checkOutput("sb_set", 64'(busy), 64'(32'h1 << 9));
    setReq(1, 5'd9, 32'h0000_0099);
    applyStimulus(3'b010, 1'b0, '0);
    checkOutput("sb_ready1", 64'(req_ready), 64'h2);
    tick();
    applyStimulus(3'b000, 1'b0, '0);
    checkOutput("sb_commit_we", 64'(we), 64'h1);
    checkOutput("sb_commit_wa", 64'(wa), 64'd9);
    checkOutput("sb_still_busy", 64'(busy), 64'(32'h1 << 9));
    tick();
    checkOutput("sb_cleared", 64'(busy), 64'h0);

    // Scoreboard: reservation coinciding with the commit keeps r9 busy (pointer at 2)
    applyStimulus(3'b000, 1'b1, 5'd9);
    tick();
    applyStimulus(3'b000, 1'b0, '0);
    setReq(2, 5'd9, 32'h0000_0077);
    applyStimulus(3'b100, 1'b0, '0);
    checkOutput("sb2_ready2", 64'(req_ready), 64'h4);
    tick();
    applyStimulus(3'b000, 1'b1, 5'd9);
    checkOutput("sb2_commit_we", 64'(we), 64'h1);
    checkOutput("sb2_commit_wd", 64'(wd), 64'h77);
    tick();
    applyStimulus(3'b000, 1'b0, '0);
    checkOutput("sb2_set_wins", 64'(busy), 64'(32'h1 << 9));
    tick();
    checkOutput("sb2_hold", 64'(busy), 64'(32'h1 << 9));

    // Reset mid-operation discards the scoreboard
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checkOutput("midrst_busy", 64'(busy), 64'h0);
    checkOutput("midrst_we", 64'(we), 64'h0);

    // Fairness: requester 0 always valid, requester 2 pulsed (pointer at 0)
    setReq(0, 5'd4, 32'h0000_0044);
    setReq(2, 5'd5, 32'h0000_0055);
    applyStimulus(3'b001, 1'b0, '0);
    checkOutput("fair_r0_first", 64'(req_ready), 64'h1);
    tick();
    applyStimulus(3'b101, 1'b0, '0);
    wait_cycles = 0;
    req2_seen   = 1'b0;
    while (!req2_seen && wait_cycles < NREQ) begin
      if (req_ready[2]) begin
        req2_seen = 1'b1;
      end else begin
        wait_cycles++;
        tick();
      end
    end
    checkOutput("fair_r2_granted", 64'(req2_seen), 64'h1);
    checkOutput("fair_r2_wait", 64'(wait_cycles), 64'h0);
    tick();
    applyStimulus(3'b001, 1'b0, '0);
    checkOutput("fair_r0_back", 64'(req_ready), 64'h1);
    checkOutput("fair_r2_write", 64'(wa), 64'd5);
    tick();
    applyStimulus(3'b101, 1'b0, '0);
    checkOutput("fair_alt_r2", 64'(req_ready), 64'h4);
    tick();
    checkOutput("fair_alt_r0", 64'(req_ready), 64'h1);
    tick();
    applyStimulus(3'b000, 1'b0, '0);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
